// File: rtl/adc_pll_reset_sequencer.sv
// Lock supervisor for the ADC clock PLL: pulses the PLL reset, qualifies lock,
// then releases the per-domain resets one at a time in a fixed order.
module adc_pll_reset_sequencer #(
  parameter int RST_PULSE_CYCLES    = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int NUM_DOMAINS         = 6,
  parameter int STAGE_GAP_CYCLES    = 8,
  parameter int MAX_RETRIES         = 7
) (
  input  logic                   refclk,
  input  logic                   rst,
  input  logic                   pll_locked,
  input  logic                   force_relock,
  output logic                   pll_rst,
  output logic [NUM_DOMAINS-1:0] domain_rst,
  output logic                   ready,
  output logic                   lock_fail,
  output logic [3:0]             retry_count,
  output logic [7:0]             lock_loss_count
);

  // One shared counter serves the reset pulse, the stable window and the stage gap.
  localparam int CNT_MAX_A = (RST_PULSE_CYCLES > LOCK_STABLE_CYCLES) ? RST_PULSE_CYCLES : LOCK_STABLE_CYCLES;
  localparam int CNT_MAX   = (CNT_MAX_A > STAGE_GAP_CYCLES) ? CNT_MAX_A : STAGE_GAP_CYCLES;
  localparam int CW        = $clog2(CNT_MAX + 1);
  localparam int TW        = $clog2(LOCK_TIMEOUT_CYCLES + 1);

  localparam logic [CW-1:0]          CNT_ONE      = CW'(1);
  localparam logic [CW-1:0]          PULSE_LAST   = CW'(RST_PULSE_CYCLES - 1);
  localparam logic [CW-1:0]          STABLE_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0]          GAP_LAST     = CW'(STAGE_GAP_CYCLES - 1);
  localparam logic [TW-1:0]          TIMER_ONE    = TW'(1);
  localparam logic [TW-1:0]          TIMEOUT_LAST = TW'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [3:0]             RETRY_LIMIT  = 4'(MAX_RETRIES);
  localparam logic [NUM_DOMAINS-1:0] ALL_RESET    = '1;

  typedef enum logic [2:0] {
    S_PLL_RST,
    S_WAIT_LOCK,
    S_STABLE,
    S_RELEASE,
    S_RUN,
    S_FAIL
  } state_t;

  state_t                 state, state_n;
  logic [CW-1:0]          cnt, cnt_n;
  logic [TW-1:0]          timer, timer_n;
  logic                   pll_rst_n, ready_n, lock_fail_n;
  logic [NUM_DOMAINS-1:0] domain_rst_n;
  logic [3:0]             retry_n;
  logic [7:0]             loss_n;
  logic                   lock_meta, lock_s;
  logic                   lock_lost, restart;

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      lock_meta <= 1'b0;
      lock_s    <= 1'b0;
    end else begin
      lock_meta <= pll_locked;
      lock_s    <= lock_meta;
    end
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state           <= S_PLL_RST;
      cnt             <= '0;
      timer           <= '0;
      pll_rst         <= 1'b1;
      domain_rst      <= ALL_RESET;
      ready           <= 1'b0;
      lock_fail       <= 1'b0;
      retry_count     <= 4'd0;
      lock_loss_count <= 8'd0;
    end else begin
      state           <= state_n;
      cnt             <= cnt_n;
      timer           <= timer_n;
      pll_rst         <= pll_rst_n;
      domain_rst      <= domain_rst_n;
      ready           <= ready_n;
      lock_fail       <= lock_fail_n;
      retry_count     <= retry_n;
      lock_loss_count <= loss_n;
    end
  end

  // Lock loss outranks a simultaneous relock request; both funnel into one restart path.
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    timer_n      = timer;
    pll_rst_n    = pll_rst;
    domain_rst_n = domain_rst;
    ready_n      = ready;
    lock_fail_n  = lock_fail;
    retry_n      = retry_count;
    loss_n       = lock_loss_count;
    restart      = 1'b0;
    lock_lost    = ((state == S_RELEASE) || (state == S_RUN)) && !lock_s;

    if (lock_lost) begin
      restart = 1'b1;
      if (lock_loss_count != 8'hFF) loss_n = lock_loss_count + 8'd1;
      if (force_relock) retry_n = 4'd0;
    end else if (force_relock && (state != S_PLL_RST)) begin
      restart     = 1'b1;
      lock_fail_n = 1'b0;
      retry_n     = 4'd0;
    end else begin
      case (state)
        S_PLL_RST: begin
          if (cnt == PULSE_LAST) begin
            state_n   = S_WAIT_LOCK;
            pll_rst_n = 1'b0;
            timer_n   = '0;
          end else begin
            cnt_n = cnt + CNT_ONE;
          end
        end
        S_WAIT_LOCK, S_STABLE: begin
          // The timeout spans the whole acquisition, including any chatter back to WAIT_LOCK.
          timer_n = timer + TIMER_ONE;
          if (timer == TIMEOUT_LAST) begin
            pll_rst_n = 1'b1;
            if (retry_count == RETRY_LIMIT) begin
              state_n     = S_FAIL;
              lock_fail_n = 1'b1;
            end else begin
              state_n = S_PLL_RST;
              cnt_n   = '0;
              retry_n = retry_count + 4'd1;
            end
          end else if (state == S_WAIT_LOCK) begin
            if (lock_s) begin
              state_n = S_STABLE;
              cnt_n   = '0;
            end
          end else if (!lock_s) begin
            state_n = S_WAIT_LOCK;
          end else if (cnt == STABLE_LAST) begin
            state_n      = S_RELEASE;
            cnt_n        = '0;
            domain_rst_n = ALL_RESET << 1;
          end else begin
            cnt_n = cnt + CNT_ONE;
          end
        end
        S_RELEASE: begin
          // Shifting zeros in from bit 0 makes out-of-order release impossible.
          if (domain_rst == '0) begin
            state_n = S_RUN;
            ready_n = 1'b1;
            retry_n = 4'd0;
          end else if (cnt == GAP_LAST) begin
            domain_rst_n = domain_rst << 1;
            cnt_n        = '0;
          end else begin
            cnt_n = cnt + CNT_ONE;
          end
        end
        S_RUN: begin
          state_n = S_RUN;
        end
        S_FAIL: begin
          state_n = S_FAIL;
        end
        default: begin
          state_n = S_PLL_RST;
        end
      endcase
    end

    if (restart) begin
      state_n      = S_PLL_RST;
      cnt_n        = '0;
      pll_rst_n    = 1'b1;
      domain_rst_n = ALL_RESET;
      ready_n      = 1'b0;
    end
  end

endmodule

// File: tb/tb_adc_pll_reset_sequencer.sv
// Testbench for adc_pll_reset_sequencer: directed bring-up, loss, timeout and reset
// scenarios, then random lock activity against a timestamp-based reference model.
module tb_adc_pll_reset_sequencer;

  localparam int RST_PULSE = 4;
  localparam int STABLE    = 8;
  localparam int TIMEOUT   = 32;
  localparam int NDOM      = 3;
  localparam int GAP       = 2;
  localparam int MAXR      = 2;

  logic            refclk = 1'b0;
  logic            rst = 1'b0;
  logic            pll_locked = 1'b0;
  logic            force_relock = 1'b0;
  logic            pll_rst;
  logic [NDOM-1:0] domain_rst;
  logic            ready;
  logic            lock_fail;
  logic [3:0]      retry_count;
  logic [7:0]      lock_loss_count;

  int tests = 0;
  int fails = 0;
  int cyc = 0;
  bit check_en = 1'b0;

  adc_pll_reset_sequencer #(
    .RST_PULSE_CYCLES(RST_PULSE),
    .LOCK_STABLE_CYCLES(STABLE),
    .LOCK_TIMEOUT_CYCLES(TIMEOUT),
    .NUM_DOMAINS(NDOM),
    .STAGE_GAP_CYCLES(GAP),
    .MAX_RETRIES(MAXR)
  ) dut (
    .refclk(refclk),
    .rst(rst),
    .pll_locked(pll_locked),
    .force_relock(force_relock),
    .pll_rst(pll_rst),
    .domain_rst(domain_rst),
    .ready(ready),
    .lock_fail(lock_fail),
    .retry_count(retry_count),
    .lock_loss_count(lock_loss_count)
  );

  always #10 refclk = ~refclk;

  always @(posedge refclk) cyc++;

  // Reference model: acquisition, released and failed phases tracked by edge timestamps.
  typedef enum {M_PULSE, M_SEEK, M_UP, M_FAILED} mphase_t;
  mphase_t ph;
  int   n, pulse_start, window_start, stable_start, release_edge, m_retry, m_loss;
  logic meta_m, ls_m;

  task automatic model_reset();
    ph = M_PULSE;
    n = 0;
    pulse_start = 0;
    window_start = 0;
    stable_start = -1;
    release_edge = 0;
    m_retry = 0;
    m_loss = 0;
    meta_m = 1'b0;
    ls_m = 1'b0;
  endtask

  task automatic start_pulse();
    ph = M_PULSE;
    pulse_start = n;
  endtask

  task automatic model_step();
    n++;
    if (ph == M_UP && !ls_m) begin
      if (m_loss < 255) m_loss++;
      if (force_relock) m_retry = 0;
      start_pulse();
    end else if (force_relock && ph != M_PULSE) begin
      m_retry = 0;
      start_pulse();
    end else if (ph == M_PULSE) begin
      if (n - pulse_start == RST_PULSE) begin
        ph = M_SEEK;
        window_start = n;
        stable_start = -1;
      end
    end else if (ph == M_SEEK) begin
      if (n - window_start == TIMEOUT) begin
        if (m_retry == MAXR) ph = M_FAILED;
        else begin
          m_retry++;
          start_pulse();
        end
      end else if (stable_start < 0) begin
        if (ls_m) stable_start = n;
      end else if (!ls_m) begin
        stable_start = -1;
      end else if (n - stable_start == STABLE) begin
        ph = M_UP;
        release_edge = n;
      end
    end else if (ph == M_UP) begin
      if (n == release_edge + (NDOM - 1) * GAP + 1) m_retry = 0;
    end
    ls_m = meta_m;
    meta_m = pll_locked;
  endtask

  always @(posedge refclk or posedge rst) begin
    if (rst) model_reset();
    else model_step();
  end

  function automatic logic [NDOM-1:0] exp_domain();
    logic [NDOM-1:0] d = '1;
    for (int i = 0; i < NDOM; i++)
      if (ph == M_UP && n >= release_edge + i * GAP) d[i] = 1'b0;
    return d;
  endfunction

  function automatic logic exp_ready();
    return (ph == M_UP) && (n >= release_edge + (NDOM - 1) * GAP + 1);
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  always @(negedge refclk) begin
    if (check_en) begin
      checkOutput("model_pll_rst", pll_rst, (ph == M_PULSE) || (ph == M_FAILED));
      checkOutput("model_domain_rst", domain_rst, exp_domain());
      checkOutput("model_ready", ready, exp_ready());
      checkOutput("model_lock_fail", lock_fail, ph == M_FAILED);
      checkOutput("model_retry_count", retry_count, m_retry);
      checkOutput("model_lock_loss_count", lock_loss_count, m_loss);
    end
  end

  task automatic applyStimulus(input logic lk, input logic fr, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      pll_locked = lk;
      force_relock = fr;
      @(posedge refclk);
      #1;
      force_relock = 1'b0;
    end
  endtask

  task automatic waitPllRstLow(input int budget);
    int c = 0;
    while (pll_rst !== 1'b0 && c < budget) begin
      applyStimulus(pll_locked, 1'b0, 1);
      c++;
    end
    checkOutput("wait_pll_rst_low", pll_rst, 1'b0);
  endtask

  task automatic waitReady(input int budget);
    int c = 0;
    while (ready !== 1'b1 && c < budget) begin
      applyStimulus(pll_locked, 1'b0, 1);
      c++;
    end
    checkOutput("wait_ready", ready, 1'b1);
  endtask

  initial begin
    int k, j, f, run;
    logic [NDOM-1:0] ed;
    logic lv;

    #1 rst = 1'b1;
    #1 check_en = 1'b1;
    checkOutput("reset_pll_rst", pll_rst, 1'b1);
    checkOutput("reset_domain_rst", domain_rst, 3'b111);
    checkOutput("reset_ready", ready, 1'b0);
    checkOutput("reset_lock_fail", lock_fail, 1'b0);
    checkOutput("reset_counts", {retry_count, lock_loss_count}, 12'h000);
    repeat (3) @(posedge refclk);
    #1 rst = 1'b0;

    // Nominal bring-up with lock raised right after the reset pulse ends.
    waitPllRstLow(20);
    pll_locked = 1'b1;
    k = cyc + 1;
    while (cyc < k + 16) begin
      applyStimulus(1'b1, 1'b0, 1);
      ed = 3'b111;
      if (cyc >= k + 10) ed[0] = 1'b0;
      if (cyc >= k + 12) ed[1] = 1'b0;
      if (cyc >= k + 14) ed[2] = 1'b0;
      checkOutput("nominal_domain_rst", domain_rst, ed);
      checkOutput("nominal_ready", ready, cyc >= k + 15);
    end
    checkOutput("nominal_retry_count", retry_count, 4'd0);

    // Lock loss while running.
    j = cyc;
    applyStimulus(1'b0, 1'b0, 2);
    checkOutput("loss_j2_domain_rst", domain_rst, 3'b000);
    checkOutput("loss_j2_ready", ready, 1'b1);
    applyStimulus(1'b0, 1'b0, 1);
    checkOutput("loss_j3_domain_rst", domain_rst, 3'b111);
    checkOutput("loss_j3_ready", ready, 1'b0);
    checkOutput("loss_j3_pll_rst", pll_rst, 1'b1);
    checkOutput("loss_j3_count", lock_loss_count, 8'd1);
    checkOutput("loss_j3_edge", cyc - j, 3);
    pll_locked = 1'b1;
    waitReady(60);
    checkOutput("relock_loss_count", lock_loss_count, 8'd1);

    // Forced relock, then lock loss just after domain 0 is released.
    applyStimulus(1'b1, 1'b1, 1);
    checkOutput("force_run_pll_rst", pll_rst, 1'b1);
    checkOutput("force_run_domain_rst", domain_rst, 3'b111);
    checkOutput("force_run_loss_count", lock_loss_count, 8'd1);
    waitPllRstLow(20);
    f = cyc;
    applyStimulus(1'b1, 1'b0, 8);
    applyStimulus(1'b0, 1'b0, 1);
    checkOutput("midrel_f9_domain_rst", domain_rst, 3'b110);
    applyStimulus(1'b0, 1'b0, 1);
    checkOutput("midrel_f10_domain_rst", domain_rst, 3'b110);
    applyStimulus(1'b0, 1'b0, 1);
    checkOutput("midrel_f11_domain_rst", domain_rst, 3'b111);
    checkOutput("midrel_f11_pll_rst", pll_rst, 1'b1);
    checkOutput("midrel_loss_count", lock_loss_count, 8'd2);
    checkOutput("midrel_edge", cyc - f, 11);
    pll_locked = 1'b1;
    waitReady(60);

    // Asynchronous reset while running, checked before any clock edge.
    @(posedge refclk);
    #3 rst = 1'b1;
    #1;
    checkOutput("async_pll_rst", pll_rst, 1'b1);
    checkOutput("async_domain_rst", domain_rst, 3'b111);
    checkOutput("async_ready", ready, 1'b0);
    checkOutput("async_loss_count", lock_loss_count, 8'd0);
    checkOutput("async_retry_count", retry_count, 4'd0);
    applyStimulus(1'b0, 1'b0, 2);
    rst = 1'b0;

    // No lock at all: three reset pulses, three timeout windows, then FAIL.
    waitPllRstLow(20);
    for (int p = 0; p < 3; p++) begin
      run = 0;
      while (pll_rst === 1'b0 && run < 100) begin
        run++;
        applyStimulus(1'b0, 1'b0, 1);
      end
      checkOutput("timeout_low_len", run, TIMEOUT);
      if (p < 2) begin
        run = 0;
        while (pll_rst === 1'b1 && run < 20) begin
          run++;
          applyStimulus(1'b0, 1'b0, 1);
        end
        checkOutput("timeout_pulse_len", run, RST_PULSE);
      end
    end
    checkOutput("fail_lock_fail", lock_fail, 1'b1);
    checkOutput("fail_retry_count", retry_count, 4'd2);
    checkOutput("fail_domain_rst", domain_rst, 3'b111);
    applyStimulus(1'b0, 1'b0, 10);
    checkOutput("fail_parked_pll_rst", pll_rst, 1'b1);
    checkOutput("fail_parked_lock_fail", lock_fail, 1'b1);
    applyStimulus(1'b0, 1'b1, 1);
    checkOutput("fail_exit_lock_fail", lock_fail, 1'b0);
    checkOutput("fail_exit_retry_count", retry_count, 4'd0);
    checkOutput("fail_exit_pll_rst", pll_rst, 1'b1);

    // Lock chatter that never completes a stable window still times out on schedule.
    waitPllRstLow(20);
    for (int t = 1; t <= 33; t++) begin
      lv = (t % 6) != 0;
      applyStimulus(lv, 1'b0, 1);
      checkOutput("chatter_pll_rst", pll_rst, t >= 32);
      checkOutput("chatter_domain_rst", domain_rst, 3'b111);
    end
    checkOutput("chatter_retry_count", retry_count, 4'd1);

    // Random lock activity with occasional relock requests and resets.
    for (int r = 0; r < 160; r++) begin
      lv = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 9) == 0) applyStimulus(lv, 1'b1, 1);
      applyStimulus(lv, 1'b0, $urandom_range(1, 50));
      if ($urandom_range(0, 24) == 0) begin
        rst = 1'b1;
        applyStimulus(lv, 1'b0, 2);
        rst = 1'b0;
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
